xlr_mcpy: RTL and testbench

XLR_MCPY -- requirements
Module: xlr_mcpy

---
 rtl/xlr_mcpy_if.sv | 28 ++
 rtl/xlr_mcpy.sv | 207 ++++++++++++++++++++
 tb/tb_xlr_mcpy.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/xlr_mcpy_if.sv
// rtl/xlr_mcpy_if.sv - host register file and XBOX memory port bundle for xlr_mcpy
interface xlr_mcpy_if #(
    parameter int NUM_MEMS           = 2,
    parameter int LOG2_LINES_PER_MEM = 8
);
    logic [31:0][31:0]                            host_regs;
    logic [31:0]                                  host_regs_valid_pulse;
    logic [31:0][31:0]                            host_regs_data_out;
    logic [31:0]                                  host_regs_valid_out;
    logic [NUM_MEMS-1:0][LOG2_LINES_PER_MEM-1:0]  xlr_mem_addr;
    logic [NUM_MEMS-1:0][7:0][31:0]               xlr_mem_wdata;
    logic [NUM_MEMS-1:0][31:0]                    xlr_mem_be;
    logic [NUM_MEMS-1:0]                          xlr_mem_rd;
    logic [NUM_MEMS-1:0]                          xlr_mem_wr;
    logic [NUM_MEMS-1:0][7:0][31:0]               xlr_mem_rdata;

    modport slave (
        input  host_regs, host_regs_valid_pulse, xlr_mem_rdata,
        output host_regs_data_out, host_regs_valid_out,
               xlr_mem_addr, xlr_mem_wdata, xlr_mem_be, xlr_mem_rd, xlr_mem_wr
    );

    modport master (
        output host_regs, host_regs_valid_pulse, xlr_mem_rdata,
        input  host_regs_data_out, host_regs_valid_out,
               xlr_mem_addr, xlr_mem_wdata, xlr_mem_be, xlr_mem_rd, xlr_mem_wr
    );
endinterface

// File: rtl/xlr_mcpy.sv
// rtl/xlr_mcpy.sv - line-by-line copy engine between XBOX memory instances
// Optional fill mode (CMD bit1) is built only when XLR_MCPY_FILL_EN is defined.
module xlr_mcpy #(
    parameter int NUM_MEMS           = 2,
    parameter int LOG2_LINES_PER_MEM = 8,
    parameter int REG_BASE           = 0
) (
    input  logic      clk,
    input  logic      rst,
    xlr_mcpy_if.slave bus
);
    localparam int L       = LOG2_LINES_PER_MEM;
    localparam int REG_SRC = REG_BASE;
    localparam int REG_DST = REG_BASE + 1;
    localparam int REG_LEN = REG_BASE + 2;
    localparam int REG_CMD = REG_BASE + 3;
    localparam logic [4:0] NMEM = 5'(NUM_MEMS);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_WT, S_WR, S_DONE} state_t;

    state_t                         r_state;
    logic [3:0]                     r_src_idx, r_dst_idx;
    logic [L-1:0]                   r_src_line, r_dst_line;
    logic [15:0]                    r_remaining, r_count;
    logic                           r_busy, r_done, r_ovr, r_err, r_valid;
    logic [NUM_MEMS-1:0]            r_rd, r_wr;
    logic [NUM_MEMS-1:0][L-1:0]     r_addr;
    logic [NUM_MEMS-1:0][7:0][31:0] r_wdata;
    logic [NUM_MEMS-1:0][31:0]      r_be;
`ifdef XLR_MCPY_FILL_EN
    logic                           r_fill;
    logic [31:0]                    r_pattern;
`endif

    logic                 w_start, w_src_bad, w_dst_bad, w_unused;
    logic [31:0]          w_src_reg, w_dst_reg, w_cmd_reg, w_status;
    logic [15:0]          w_len;
    logic [L-1:0]         w_src_next, w_dst_next;
    logic [7:0][31:0]     w_rdata_sel;
    logic [31:0][31:0]    w_data_out;
    logic [31:0]          w_valid_out;

    assign w_src_reg  = bus.host_regs[REG_SRC];
    assign w_dst_reg  = bus.host_regs[REG_DST];
    assign w_cmd_reg  = bus.host_regs[REG_CMD];
    assign w_len      = bus.host_regs[REG_LEN][15:0];
    assign w_start    = bus.host_regs_valid_pulse[REG_CMD] && w_cmd_reg[0];
    assign w_dst_bad  = {1'b0, w_dst_reg[19:16]} >= NMEM;
`ifdef XLR_MCPY_FILL_EN
    // In fill mode SRC carries the pattern, so its index field is meaningless
    assign w_src_bad  = !w_cmd_reg[1] && ({1'b0, w_src_reg[19:16]} >= NMEM);
`else
    assign w_src_bad  = {1'b0, w_src_reg[19:16]} >= NMEM;
`endif
    assign w_src_next = r_src_line + L'(1);
    assign w_dst_next = r_dst_line + L'(1);
    assign w_unused   = ^{bus.host_regs, bus.host_regs_valid_pulse};

    always_comb begin
        w_rdata_sel = '0;
        for (int m = 0; m < NUM_MEMS; m++)
            if (4'(m) == r_src_idx) w_rdata_sel = bus.xlr_mem_rdata[m];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_src_idx   <= '0;
            r_dst_idx   <= '0;
            r_src_line  <= '0;
            r_dst_line  <= '0;
            r_remaining <= '0;
            r_count     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_ovr       <= 1'b0;
            r_err       <= 1'b0;
            r_valid     <= 1'b0;
            r_rd        <= '0;
            r_wr        <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_be        <= '0;
`ifdef XLR_MCPY_FILL_EN
            r_fill      <= 1'b0;
            r_pattern   <= '0;
`endif
        end else begin
            // Memory strobes and buses are one-cycle pulses, re-armed per state
            r_rd    <= '0;
            r_wr    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            if (w_start && r_state != S_IDLE) r_ovr <= 1'b1;
            case (r_state)
                S_IDLE: if (w_start) begin
                    r_valid     <= 1'b1;
                    r_done      <= 1'b0;
                    r_ovr       <= 1'b0;
                    r_err       <= 1'b0;
                    r_count     <= '0;
                    r_src_idx   <= w_src_reg[19:16];
                    r_src_line  <= w_src_reg[L-1:0];
                    r_dst_idx   <= w_dst_reg[19:16];
                    r_dst_line  <= w_dst_reg[L-1:0];
                    r_remaining <= w_len;
`ifdef XLR_MCPY_FILL_EN
                    r_fill      <= w_cmd_reg[1];
                    r_pattern   <= w_src_reg;
`endif
                    if (w_src_bad || w_dst_bad) begin
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (w_len == 16'd0) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
`ifdef XLR_MCPY_FILL_EN
                    else if (w_cmd_reg[1]) begin
                        r_busy <= 1'b1;
                        for (int m = 0; m < NUM_MEMS; m++)
                            if (4'(m) == w_dst_reg[19:16]) begin
                                r_wr[m]    <= 1'b1;
                                r_addr[m]  <= w_dst_reg[L-1:0];
                                r_wdata[m] <= {8{w_src_reg}};
                                r_be[m]    <= '1;
                            end
                        r_state <= S_WR;
                    end
`endif
                    else begin
                        r_busy <= 1'b1;
                        for (int m = 0; m < NUM_MEMS; m++)
                            if (4'(m) == w_src_reg[19:16]) begin
                                r_rd[m]   <= 1'b1;
                                r_addr[m] <= w_src_reg[L-1:0];
                            end
                        r_state <= S_RD;
                    end
                end
                S_RD: r_state <= S_WT;
                S_WT: begin
                    for (int m = 0; m < NUM_MEMS; m++)
                        if (4'(m) == r_dst_idx) begin
                            r_wr[m]    <= 1'b1;
                            r_addr[m]  <= r_dst_line;
                            r_wdata[m] <= w_rdata_sel;
                            r_be[m]    <= '1;
                        end
                    r_state <= S_WR;
                end
                S_WR: begin
                    r_count     <= r_count + 16'd1;
                    r_remaining <= r_remaining - 16'd1;
                    r_src_line  <= w_src_next;
                    r_dst_line  <= w_dst_next;
                    if (r_remaining == 16'd1) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
`ifdef XLR_MCPY_FILL_EN
                    else if (r_fill) begin
                        for (int m = 0; m < NUM_MEMS; m++)
                            if (4'(m) == r_dst_idx) begin
                                r_wr[m]    <= 1'b1;
                                r_addr[m]  <= w_dst_next;
                                r_wdata[m] <= {8{r_pattern}};
                                r_be[m]    <= '1;
                            end
                        r_state <= S_WR;
                    end
`endif
                    else begin
                        for (int m = 0; m < NUM_MEMS; m++)
                            if (4'(m) == r_src_idx) begin
                                r_rd[m]   <= 1'b1;
                                r_addr[m] <= w_src_next;
                            end
                        r_state <= S_RD;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_status = {r_busy, r_done, r_ovr, r_err, 12'd0, r_count};

    always_comb begin
        w_data_out           = '0;
        w_data_out[REG_CMD]  = w_status;
        w_valid_out          = '0;
        w_valid_out[REG_CMD] = r_valid;
    end

    assign bus.host_regs_data_out  = w_data_out;
    assign bus.host_regs_valid_out = w_valid_out;
    assign bus.xlr_mem_rd          = r_rd;
    assign bus.xlr_mem_wr          = r_wr;
    assign bus.xlr_mem_addr        = r_addr;
    assign bus.xlr_mem_wdata       = r_wdata;
    assign bus.xlr_mem_be          = r_be;
endmodule

// File: tb/tb_xlr_mcpy.sv
// tb/tb_xlr_mcpy.sv - scoreboard bench for xlr_mcpy with a two-instance memory model
module tb_xlr_mcpy;
    logic clk;
    logic rst;
    int   n_asserts;
    int   n_fail;

    xlr_mcpy_if #(.NUM_MEMS(2), .LOG2_LINES_PER_MEM(8)) bus ();

    xlr_mcpy #(.NUM_MEMS(2), .LOG2_LINES_PER_MEM(8), .REG_BASE(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct packed {
        logic [3:0]   idx;
        logic [7:0]   addr;
        logic [255:0] data;
    } ent_t;

    ent_t exp_rd[$];
    ent_t exp_wr[$];
    ent_t e_mon;

    logic [255:0] mem [2][256];
    bit           written [2][256];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [255:0] init_line(input int m, input int a);
        logic [255:0] r;
        for (int w = 0; w < 8; w++) r[w*32 +: 32] = 32'hC000_0000 | (m << 24) | ((a & 255) << 8) | w;
        return r;
    endfunction

    function automatic logic [255:0] rd_line(input int m, input int a);
        return written[m][a] ? mem[m][a] : init_line(m, a);
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_asserts++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory model: read data returns one cycle after the read strobe
    always @(posedge clk) begin
        if (rst) bus.xlr_mem_rdata <= '0;
        else for (int m = 0; m < 2; m++) begin
            if (bus.xlr_mem_rd[m]) bus.xlr_mem_rdata[m] <= rd_line(m, int'(bus.xlr_mem_addr[m]));
            if (bus.xlr_mem_wr[m]) begin
                mem[m][bus.xlr_mem_addr[m]]     <= bus.xlr_mem_wdata[m];
                written[m][bus.xlr_mem_addr[m]] <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) for (int m = 0; m < 2; m++) begin
            if (bus.xlr_mem_rd[m]) begin
                if (exp_rd.size() == 0) chk("rd_unexpected", bus.xlr_mem_rd[m], 0);
                else begin
                    e_mon = exp_rd.pop_front();
                    chk("rd_idx", m, e_mon.idx);
                    chk("rd_addr", bus.xlr_mem_addr[m], e_mon.addr);
                end
            end
            if (bus.xlr_mem_wr[m]) begin
                if (exp_wr.size() == 0) chk("wr_unexpected", bus.xlr_mem_wr[m], 0);
                else begin
                    e_mon = exp_wr.pop_front();
                    chk("wr_idx", m, e_mon.idx);
                    chk("wr_addr", bus.xlr_mem_addr[m], e_mon.addr);
                    chk("wr_data", bus.xlr_mem_wdata[m], e_mon.data);
                    chk("wr_be", bus.xlr_mem_be[m], 32'hFFFF_FFFF);
                end
            end
        end
    end

    task automatic push_copy(input int si, input int sl, input int di, input int dl, input int n);
        for (int i = 0; i < n; i++) begin
            exp_rd.push_back({4'(si), 8'(sl + i), 256'd0});
            exp_wr.push_back({4'(di), 8'(dl + i), init_line(si, (sl + i) & 255)});
        end
    endtask

    task automatic issue(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l, input logic [31:0] c);
        @(negedge clk);
        bus.host_regs[0]          = s;
        bus.host_regs[1]          = d;
        bus.host_regs[2]          = l;
        bus.host_regs[3]          = c;
        bus.host_regs_valid_pulse = 32'hF;
        @(posedge clk);
        #1 bus.host_regs_valid_pulse = '0;
    endtask

    task automatic wait_done(input int limit, output int cyc);
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (bus.host_regs_data_out[3][30]) break;
            if (cyc >= limit) begin
                chk("done_timeout", bus.host_regs_data_out[3][30], 1);
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        n_asserts = 0;
        n_fail    = 0;
        rst = 1'b1;
        bus.host_regs = '0;
        bus.host_regs_valid_pulse = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_status", bus.host_regs_data_out, '0);
        chk("rst_valid_out", bus.host_regs_valid_out, 0);
        chk("rst_strobes", {bus.xlr_mem_rd, bus.xlr_mem_wr}, 0);
        chk("rst_addr", bus.xlr_mem_addr, 0);
        @(negedge clk);
        rst = 1'b0;

        // mem0 lines 0x10..0x13 -> mem1 lines 0x20..0x23
        push_copy(0, 8'h10, 1, 8'h20, 4);
        issue(32'h0000_0010, 32'h0001_0020, 32'd4, 32'd1);
        chk("valid_out_after_start", bus.host_regs_valid_out, 32'h8);
        wait_done(60, cyc);
        chk("copy4_cycles", cyc, 12);
        chk("copy4_status", bus.host_regs_data_out[3], 32'h4000_0004);

        issue(32'h0000_0010, 32'h0001_0020, 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("len0_status", bus.host_regs_data_out[3], 32'h4000_0000);

        // line address wrap at 2^8
        push_copy(0, 8'hFE, 1, 8'h40, 3);
        issue(32'h0000_00FE, 32'h0001_0040, 32'd3, 32'd1);
        wait_done(60, cyc);
        chk("wrap_cycles", cyc, 9);
        chk("wrap_status", bus.host_regs_data_out[3], 32'h4000_0003);

        // start re-pulsed while busy
        push_copy(0, 8'h08, 1, 8'h60, 2);
        issue(32'h0000_0008, 32'h0001_0060, 32'd2, 32'd1);
        @(negedge clk);
        chk("busy_status", bus.host_regs_data_out[3], 32'h8000_0000);
        bus.host_regs_valid_pulse = 32'h8;
        @(posedge clk);
        #1 bus.host_regs_valid_pulse = '0;
        wait_done(60, cyc);
        chk("ovr_cycles", cyc, 5);
        chk("ovr_status", bus.host_regs_data_out[3], 32'h6000_0002);

        issue(32'h0005_0000, 32'h0001_0000, 32'd4, 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("err_src_status", bus.host_regs_data_out[3], 32'h5000_0000);
        issue(32'h0000_0000, 32'h0002_0000, 32'd1, 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("err_dst_status", bus.host_regs_data_out[3], 32'h5000_0000);

        // reset while writing the second line
        exp_rd.push_back({4'd0, 8'h30, 256'd0});
        exp_rd.push_back({4'd0, 8'h31, 256'd0});
        exp_wr.push_back({4'd1, 8'h70, init_line(0, 8'h30)});
        issue(32'h0000_0030, 32'h0001_0070, 32'd4, 32'd1);
        repeat (5) @(posedge clk);
        #2;
        chk("wr_before_rst", bus.xlr_mem_wr[1], 1);
        rst = 1'b1;
        #1;
        chk("rst_mid_strobes", {bus.xlr_mem_rd, bus.xlr_mem_wr}, 0);
        chk("rst_mid_status", bus.host_regs_data_out[3], 0);
        chk("rst_mid_valid_out", bus.host_regs_valid_out, 0);
        chk("rst_mid_wdata", bus.xlr_mem_wdata, 0);
        @(negedge clk);
        rst = 1'b0;
        push_copy(0, 8'h30, 1, 8'h70, 2);
        issue(32'h0000_0030, 32'h0001_0070, 32'd2, 32'd1);
        wait_done(60, cyc);
        chk("post_rst_cycles", cyc, 6);
        chk("post_rst_status", bus.host_regs_data_out[3], 32'h4000_0002);
        chk("post_rst_valid_out", bus.host_regs_valid_out, 32'h8);

`ifdef XLR_MCPY_FILL_EN
        exp_wr.push_back({4'd0, 8'h00, {8{32'hA5A5_A5A5}}});
        exp_wr.push_back({4'd0, 8'h01, {8{32'hA5A5_A5A5}}});
        issue(32'hA5A5_A5A5, 32'h0000_0000, 32'd2, 32'd3);
        wait_done(60, cyc);
        chk("fill_cycles", cyc, 2);
        chk("fill_status", bus.host_regs_data_out[3], 32'h4000_0002);
`else
        push_copy(0, 8'h50, 1, 8'h50, 1);
        issue(32'h0000_0050, 32'h0001_0050, 32'd1, 32'd3);
        wait_done(60, cyc);
        chk("bit1_copy_cycles", cyc, 3);
        chk("bit1_copy_status", bus.host_regs_data_out[3], 32'h4000_0001);
`endif

        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) chk("mem1_copy", rd_line(1, 8'h20 + i), init_line(0, 8'h10 + i));
        chk("mem1_wrap_last", rd_line(1, 8'h42), init_line(0, 8'h00));
        chk("mem1_partial_line_skipped", rd_line(1, 8'h72), init_line(1, 8'h72));
        chk("rd_queue_drained", exp_rd.size(), 0);
        chk("wr_queue_drained", exp_wr.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
